// File: rtl/disaggregator_if.sv
// Wide-sender / narrow-receiver handshake bundle for the disaggregator.
// slave faces the disaggregator; master faces the surrounding logic.
interface disaggregator_if #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned FETCH_WIDTH = 4
);
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;
  logic                              receiver_last;
  logic                              busy;

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq, receiver_last, busy
  );

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq, receiver_last, busy
  );
endinterface

// File: rtl/disaggregator.sv
// Splits one FETCH_WIDTH*DATA_WIDTH word into FETCH_WIDTH narrow words, lane 0 first,
// reloading on the last lane so back-to-back wide words stream without a bubble.
module disaggregator #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned FETCH_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  disaggregator_if.slave bus
);
  localparam int unsigned    LW        = $clog2(FETCH_WIDTH);
  localparam logic [LW-1:0]  LAST_LANE = LW'(FETCH_WIDTH - 1);

  typedef enum logic {EMPTY, LOADED} state_t;

  state_t                                 state, state_next;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] hold_reg;
  logic [LW-1:0]                          lane;
  logic                                   valid, enq, deq, last_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (deq) state_next = LOADED;
      LOADED:  if (last_fire && !deq) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // rst_n gates the pop so the sender is never drained while reset is held.
  always_comb begin
    valid     = (state == LOADED);
    enq       = valid & bus.receiver_full_n;
    last_fire = enq & (lane == LAST_LANE);
    deq       = rst_n & bus.sender_empty_n & (~valid | last_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
      lane     <= '0;
    end else if (deq) begin
      hold_reg <= bus.sender_data;
      lane     <= '0;
    end else if (last_fire) begin
      lane     <= '0;
    end else if (enq) begin
      lane     <= lane + 1'b1;
    end
  end

  assign bus.sender_deq    = deq;
  assign bus.receiver_enq  = enq;
  assign bus.receiver_data = hold_reg[lane];
  assign bus.receiver_last = valid & (lane == LAST_LANE);
  assign bus.busy          = valid;
endmodule
